// File: rtl/triple_port_register_file.sv
// Three-read, one-write register bank with registered read ports and a saturating write counter.
// Build option: define REGFILE_BYPASS_EN for write-first forwarding on same-edge address collisions.

module triple_port_register_file #(
  parameter int unsigned DataW = 8,
  parameter int unsigned Depth = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             read_en_i,
  input  logic [3:0]       read_reg1_i,
  input  logic [3:0]       read_reg2_i,
  input  logic [3:0]       read_reg3_i,
  input  logic             write_en_i,
  input  logic [3:0]       write_reg_i,
  input  logic [DataW-1:0] write_data_i,
  output logic [DataW-1:0] read_data1_o,
  output logic [DataW-1:0] read_data2_o,
  output logic [DataW-1:0] read_data3_o,
  output logic             read_valid_o,
  output logic [4:0]       write_count_o,
  output logic             all_written_o
);

  localparam int unsigned NumPorts = 3;
  localparam logic [4:0]  CountMax = 5'(Depth);

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] mem_d [Depth];
  logic [DataW-1:0] rd_q  [NumPorts];
  logic [DataW-1:0] rd_d  [NumPorts];
  logic [3:0]       raddr [NumPorts];
  logic             valid_q, valid_d;
  logic [4:0]       count_q, count_d;

  assign raddr[0] = read_reg1_i;
  assign raddr[1] = read_reg2_i;
  assign raddr[2] = read_reg3_i;

  always_comb begin
    mem_d = mem_q;
    if (write_en_i) begin
      mem_d[write_reg_i] = write_data_i;
    end
  end

  // Read ports sample the pre-write array; the bypass build overrides with incoming data.
  always_comb begin
    rd_d    = rd_q;
    valid_d = read_en_i;
    if (read_en_i) begin
      for (int p = 0; p < NumPorts; p++) begin
        rd_d[p] = mem_q[raddr[p]];
`ifdef REGFILE_BYPASS_EN
        if (write_en_i && (write_reg_i == raddr[p])) begin
          rd_d[p] = write_data_i;
        end
`endif
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (write_en_i && (count_q != CountMax)) begin
      count_d = count_q + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      for (int p = 0; p < NumPorts; p++) begin
        rd_q[p] <= '0;
      end
      valid_q <= 1'b0;
      count_q <= 5'd0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign read_data1_o  = rd_q[0];
  assign read_data2_o  = rd_q[1];
  assign read_data3_o  = rd_q[2];
  assign read_valid_o  = valid_q;
  assign write_count_o = count_q;
  assign all_written_o = (count_q == CountMax);

endmodule
